mod_addsub_pipe: RTL and testbench

Parametrised, pipelined modular add/subtract unit for the NTT datapath. It computes (a op b) mod Q on operands already reduced to [0, Q). It supports four operation modes and a valid/ready handshake with full backpressure. It sits between the butterfly multiplier output and the coefficient write-back, and it replaces the combinational subtractor in timing-critical paths.

---
 rtl/ntt_pkg.sv | 14 +
 rtl/mod_reduce_sel.sv | 27 ++
 rtl/mod_addsub_pipe.sv | 146 ++++++++++++++
 tb/tb_mod_addsub_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions: Kyber constants and the add/sub operation encoding.
package ntt_pkg;

  localparam int Q_KYBER = 3329;
  localparam int W_KYBER = 12;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NEG  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

endpackage

// File: rtl/mod_reduce_sel.sv
// Final modular select: picks raw or its pre-computed Q-corrected alternative, result in [0, Q).
module mod_reduce_sel
  import ntt_pkg::*;
#(
  parameter int W = W_KYBER,
  parameter int Q = Q_KYBER
) (
  input  op_e          op,
  input  logic [W:0]   raw,
  input  logic [W:0]   alt,
  output logic [W-1:0] res
);

  localparam logic [W:0] QX = (W+1)'(Q);

  always_comb begin
    res = raw[W-1:0];
    case (op)
      // alt = raw-Q; its sign bit is clear exactly when raw >= Q, so no separate comparator
      OP_ADD:  if (!alt[W]) res = alt[W-1:0];
      OP_SUB:  if (raw[W]) res = alt[W-1:0];
      OP_NEG:  if (raw == QX) res = '0;
      default: res = raw[W-1:0];
    endcase
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular add/sub/neg/pass with valid/ready backpressure.
// Optional MOD_ADDSUB_RANGE_CHK_EN adds range_err, flagging operands >= Q at acceptance.
module mod_addsub_pipe
  import ntt_pkg::*;
#(
  parameter int W     = W_KYBER,
  parameter int Q     = Q_KYBER,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  ,
  output logic             range_err
`endif
);

  localparam logic [W:0] QX = (W+1)'(Q);

  typedef struct packed {
    op_e              op;
    logic [W:0]       raw;
    logic [W:0]       alt;
    logic [TAG_W-1:0] tag;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    logic             err;
`endif
  } pay_t;

  logic             s1_valid_q, s1_valid_d;
  pay_t             s1_q, s1_d, pay_in;
  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     s2_data_q, s2_data_d, s2_res;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  logic             s2_err_q, s2_err_d;
`endif
  logic             s1_adv, s2_adv;
  logic [W:0]       a_x, b_x, sum_x, dif_x;

  assign a_x   = {1'b0, in_a};
  assign b_x   = {1'b0, in_b};
  assign sum_x = a_x + b_x;
  assign dif_x = a_x - b_x;

  always_comb begin
    pay_in     = '0;
    pay_in.op  = op_e'(in_op);
    pay_in.tag = in_tag;
    case (op_e'(in_op))
      OP_ADD: begin
        pay_in.raw = sum_x;
        pay_in.alt = sum_x - QX;
      end
      OP_SUB: begin
        pay_in.raw = dif_x;
        pay_in.alt = dif_x + QX;
      end
      OP_NEG:  pay_in.raw = QX - b_x;
      default: pay_in.raw = a_x;
    endcase
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    pay_in.err = (a_x >= QX) || (b_x >= QX);
`endif
  end

  mod_reduce_sel #(
    .W (W),
    .Q (Q)
  ) u_reduce_sel (
    .op  (s1_q.op),
    .raw (s1_q.raw),
    .alt (s1_q.alt),
    .res (s2_res)
  );

  assign s2_adv = !s2_valid_q || out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    s2_err_d   = s2_err_q;
`endif
    // S2 payload only loads on a real operation, so data/tag stay put across bubbles
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s2_res;
        s2_tag_d  = s1_q.tag;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        s2_err_d  = s1_q.err;
`endif
      end
    end
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_d = pay_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      s2_err_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      s2_err_q   <= s2_err_d;
`endif
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  assign range_err = s2_err_q;
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: directed corners, backpressure, reset flush, random scoreboard.
module tb_mod_addsub_pipe;

  localparam int W     = 12;
  localparam int Q     = 3329;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  logic             range_err;
`endif

  always #5 clk = ~clk;

  mod_addsub_pipe #(
    .W     (W),
    .Q     (Q),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    .range_err (range_err),
`endif
    .out_tag   (out_tag)
  );

  typedef struct {
    int data;
    int tag;
    bit err;
  } exp_t;

  exp_t             exp_q[$];
  int               n_chk  = 0;
  int               n_pass = 0;
  int               n_acc  = 0;
  int               n_emit = 0;
  bit               prev_stall = 1'b0;
  logic [W-1:0]     prev_data;
  logic [TAG_W-1:0] prev_tag;
  bit               saw_ready;
  bit               last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: plain modular arithmetic on integers
  function automatic int model(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) % Q;
      1:       return (a - b + Q) % Q;
      2:       return (Q - b) % Q;
      default: return a;
    endcase
  endfunction

  task automatic set_in(input int op, input int a, input int b, input int tag);
    in_op  = 2'(op);
    in_a   = W'(a);
    in_b   = W'(b);
    in_tag = TAG_W'(tag);
  endtask

  // One cycle of scoreboard bookkeeping: call at a negedge with inputs driven, returns at the next negedge
  task automatic tick();
    exp_t e;
    #1;
    saw_ready = in_ready;
    last_acc  = 1'b0;
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'(prev_data));
      chk("stall_tag", 32'(out_tag), 32'(prev_tag));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        if (!e.err) chk("data", 32'(out_data), e.data);
        chk("tag", 32'(out_tag), e.tag);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        chk("range_err", 32'(range_err), 32'(e.err));
`endif
        n_emit++;
      end
    end
    if (in_valid && in_ready) begin
      e.data = model(int'(in_op), int'(in_a), int'(in_b));
      e.tag  = int'(in_tag);
      e.err  = (int'(in_a) >= Q) || (int'(in_b) >= Q);
      exp_q.push_back(e);
      n_acc++;
      last_acc = 1'b1;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_tag   = out_tag;
    @(negedge clk);
  endtask

  // Single op with an idle pipeline: checks the exact 2-cycle latency, value and tag
  task automatic directed(input string name, input int op, input int a, input int b,
                          input int tag, input int exp);
    set_in(op, a, b, tag);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 chk({name, "_in_ready"}, 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({name, "_lat1"}, 32'(out_valid), 0);
    @(negedge clk);
    #1;
    chk({name, "_lat2"}, 32'(out_valid), 1);
    chk({name, "_data"}, 32'(out_data), exp);
    chk({name, "_tag"}, 32'(out_tag), tag);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_in(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);

    directed("sub_nowrap", 1, 3320, 5, 8'h11, 3315);
    directed("sub_wrap", 1, 3, 35, 8'h12, 3297);
    directed("sub_zero", 1, 3320, 3320, 8'h13, 0);
    directed("neg_zero", 2, 7, 0, 8'h14, 0);
    directed("neg_one", 2, 7, 1, 8'h15, 3328);
    directed("add_wrap", 0, 3000, 400, 8'h16, 71);
    directed("add_q", 0, 3328, 1, 8'h17, 0);
    directed("add_max", 0, 1664, 1664, 8'h18, 3328);
    directed("pass", 3, 1234, 999, 8'h19, 1234);

    // Backpressure: five back-to-back ops, output stalled for four cycles
    out_ready = 1'b0;
    idx  = 0;
    base = n_emit;
    for (int c = 0; c < 4; c++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, Q-1), $urandom_range(0, Q-1), 8'hA0 + idx);
      in_valid = 1'b1;
      tick();
      if (last_acc) idx++;
      if (c >= 2) chk("bp_in_ready_low", 32'(saw_ready), 0);
    end
    chk("bp_accepted_before_release", idx, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (idx < 5 || exp_q.size() > 0); c++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, Q-1), $urandom_range(0, Q-1), 8'hA0 + idx);
      in_valid = (idx < 5);
      tick();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_emitted", n_emit - base, 5);
    chk("bp_drained", exp_q.size(), 0);

    // Reset with both stages full
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      set_in(0, $urandom_range(0, Q-1), $urandom_range(0, Q-1), 8'hC0 + c);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    out_ready  = 1'b1;
    #1;
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_out_data", 32'(out_data), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      #1 chk("flush_no_stale", 32'(out_valid), 0);
      @(negedge clk);
    end

    // Random traffic against the scoreboard
    base = n_acc;
    for (int c = 0; c < 40000 && (n_acc - base) < 10000; c++) begin
      int a;
      a = $urandom_range(0, Q-1);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      if ($urandom_range(0, 63) == 0) a = Q;
`endif
      set_in($urandom_range(0, 3), a, $urandom_range(0, Q-1), $urandom_range(0, 255));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("rand_accepted", n_acc - base, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick();
    chk("rand_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
